mem_stage_ctrl: RTL and testbench

MEM-stage memory access controller; consumes the registered EX/MEM outputs and drives a Wishbone classic master bus for loads and stores. It holds the access in flight and raises a stall request until the slave acknowledges. It then returns load data to the MEM/WB register. It is the consumer end of the EX/MEM register and the producer of that register's stall bit, through the hazard unit.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_stage_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
// Sub-word funct3 encodings are only consumed when MEM_SUBWORD_EN is defined.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // RISC-V load/store funct3 encodings; stores reuse the low two bits.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it. Used only when MEM_SUBWORD_EN is defined.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfwords ignore addr[0]; the lane is chosen by addr[1] alone.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage Wishbone classic master: holds a load/store in flight, stalls the
// pipeline until ack, returns load data. MEM_SUBWORD_EN adds byte/halfword access.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
`ifdef MEM_SUBWORD_EN
  input  logic [2:0]              mem_funct3,
`endif
  output logic                    mem_busy,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  state_t                  r_state;
  logic                    r_cyc;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [DATA_WIDTH/8-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_req;
  logic [DATA_WIDTH/8-1:0] w_store_sel;
  logic [DATA_WIDTH-1:0]   w_store_data;
  logic [DATA_WIDTH-1:0]   w_load_data;

  assign w_req = mem_read | mem_write;

`ifdef MEM_SUBWORD_EN
  logic [2:0] r_funct3;
  logic [1:0] r_addr_lo;

  always_comb begin
    w_store_sel  = 4'b1111;
    w_store_data = mem_wdata;
    case (mem_funct3[1:0])
      2'b00: begin
        w_store_sel  = 4'b0001 << mem_addr[1:0];
        w_store_data = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        w_store_sel  = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Size and lane are captured with the request so the aligner does not depend
  // on the EX/MEM register staying put through the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
    end else if (r_state == IDLE && w_req) begin
      r_funct3  <= mem_funct3;
      r_addr_lo <= mem_addr[1:0];
    end
  end

  mem_load_align u_load_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (wb_dat_i),
    .o_data    (w_load_data)
  );
`else
  logic w_unused_addr_lo;

  assign w_unused_addr_lo = ^mem_addr[1:0];
  assign w_store_sel      = '1;
  assign w_store_data     = mem_wdata;
  assign w_load_data      = wb_dat_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cyc   <= 1'b1;
            r_we    <= mem_write;
            r_adr   <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            r_dat   <= w_store_data;
            r_sel   <= w_store_sel;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (wb_ack_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            if (!r_we) r_rdata <= w_load_data;
            r_state <= DONE;
          end
        end
        // The EX/MEM inputs still hold the finished instruction here.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_busy  = ((r_state == IDLE) && w_req) || (r_state == ACCESS);
  assign mem_rdata = r_rdata;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_sel;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed and random loads/stores
// against a transaction-level model; MEM_SUBWORD_EN enables sub-word cases.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int          totalChecks = 0;
  int          badChecks = 0;
  logic [31:0] modelRdata;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
`ifdef MEM_SUBWORD_EN
    .mem_funct3 (mem_funct3),
`endif
    .mem_busy   (mem_busy),
    .mem_rdata  (mem_rdata),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: byte lanes and extension from the access rules, in plain arithmetic.
  function automatic logic [3:0] expSel(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_SUBWORD_EN
    int lane = int'(addr % 4);
    if (f3 == F3_B || f3 == F3_BU) return 4'(1 << lane);
    if (f3 == F3_H || f3 == F3_HU) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
`else
    return (f3 === 3'bxxx) ? 4'b0000 : 4'b1111;
`endif
  endfunction

  function automatic logic [31:0] expStore(input logic [2:0] f3, input logic [31:0] wdata);
`ifdef MEM_SUBWORD_EN
    logic [31:0] b = wdata % 256;
    logic [31:0] h = wdata % 65536;
    if (f3 == F3_B) return b * 32'h0101_0101;
    if (f3 == F3_H) return h * 32'h0001_0001;
    return wdata;
`else
    return (f3 === 3'bxxx) ? 32'd0 : wdata;
`endif
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
`ifdef MEM_SUBWORD_EN
    int lane = int'(addr % 4);
    logic [31:0] b = (d >> (8 * lane)) % 256;
    logic [31:0] h = (d >> (16 * (lane / 2))) % 65536;
    if (f3 == F3_BU) return b;
    if (f3 == F3_HU) return h;
    if (f3 == F3_B)  return (b >= 128) ? b - 256 : b;
    if (f3 == F3_H)  return (h >= 32768) ? h - 65536 : h;
    return d;
`else
    return (f3 === 3'bxxx) ? 32'd0 : (addr === 32'hx ? 32'd0 : d);
`endif
  endfunction

  // One complete access: request in cycle 0, ack in cycle k, DONE in cycle k+1.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input int k, input logic [31:0] ackData);
    logic [3:0]  eSel;
    logic [31:0] eDat;
    eSel = expSel(f3, addr);
    eDat = expStore(f3, wdata);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata; mem_funct3 = f3;
    wb_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("req_busy", {63'd0, mem_busy}, 64'd1);
    checkOutput("req_cyc", {63'd0, wb_cyc_o}, 64'd0);
    @(posedge clk); #1;
    for (int j = 1; j <= k; j++) begin
      wb_ack_i = (j == k);
      wb_dat_i = (j == k) ? ackData : $urandom;
      @(negedge clk);
      checkOutput("acc_cyc", {63'd0, wb_cyc_o}, 64'd1);
      checkOutput("acc_stb", {63'd0, wb_stb_o}, 64'd1);
      checkOutput("acc_we", {63'd0, wb_we_o}, {63'd0, wr});
      checkOutput("acc_adr", {32'd0, wb_adr_o}, {32'd0, addr - (addr % 4)});
      checkOutput("acc_dat", {32'd0, wb_dat_o}, {32'd0, eDat});
      checkOutput("acc_sel", {60'd0, wb_sel_o}, {60'd0, eSel});
      checkOutput("acc_busy", {63'd0, mem_busy}, 64'd1);
      @(posedge clk); #1;
    end
    wb_ack_i = 1'b0;
    wb_dat_i = $urandom;
    if (rd && !wr) modelRdata = expLoad(f3, addr, ackData);
    @(negedge clk);
    checkOutput("done_busy", {63'd0, mem_busy}, 64'd0);
    checkOutput("done_cyc", {63'd0, wb_cyc_o}, 64'd0);
    checkOutput("done_we", {63'd0, wb_we_o}, 64'd0);
    checkOutput("done_rdata", {32'd0, mem_rdata}, {32'd0, modelRdata});
    @(posedge clk); #1;
  endtask

  task automatic idleCycle(input logic strayAck);
    mem_read = 1'b0; mem_write = 1'b0;
    wb_ack_i = strayAck; wb_dat_i = $urandom;
    @(negedge clk);
    checkOutput("idle_busy", {63'd0, mem_busy}, 64'd0);
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("idle_cyc", {63'd0, wb_cyc_o}, 64'd0);
    checkOutput("idle_rdata", {32'd0, mem_rdata}, {32'd0, modelRdata});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3Pick [5];
    f3Pick[0] = F3_B; f3Pick[1] = F3_H; f3Pick[2] = F3_W; f3Pick[3] = F3_BU; f3Pick[4] = F3_HU;
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_funct3 = F3_W;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    modelRdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {63'd0, mem_busy}, 64'd0);
    checkOutput("rst_rdata", {32'd0, mem_rdata}, 64'd0);
    checkOutput("rst_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    checkOutput("rst_we", {63'd0, wb_we_o}, 64'd0);
    checkOutput("rst_adr", {32'd0, wb_adr_o}, 64'd0);
    checkOutput("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    checkOutput("rst_sel", {60'd0, wb_sel_o}, 64'd0);
    @(posedge clk); #1;
    idleCycle(1'b1);

    applyStimulus(1'b1, 1'b0, 32'h8000_0010, 32'h0, F3_W, 1, 32'hDEAD_BEEF);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678, F3_W, 4, 32'h0);
    // Back-to-back: second request presented right after DONE.
    applyStimulus(1'b1, 1'b0, 32'h8000_0020, 32'h0, F3_W, 2, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b1, 32'h8000_0024, 32'hA5A5_5A5A, F3_W, 1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0008, 32'h0BAD_0BAD, F3_W, 2, 32'h1111_2222);

    for (int n = 0; n < 40; n++) begin
      int          op;
      logic [2:0]  f3;
      op = int'($urandom_range(0, 2));
      f3 = (op == 0) ? f3Pick[$urandom_range(0, 4)] : f3Pick[$urandom_range(0, 2)];
      applyStimulus(op != 1, op != 0, $urandom, $urandom, f3, int'($urandom_range(1, 4)), $urandom);
      if ($urandom_range(0, 1) == 1) idleCycle(1'($urandom_range(0, 1)));
    end

    // Reset during ACCESS must drop the bus cycle asynchronously.
    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h8000_0040; mem_funct3 = F3_W;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_cyc_before", {63'd0, wb_cyc_o}, 64'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    modelRdata = 32'd0;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 32'h8000_0010, 32'h0, F3_W, 1, 32'h7654_3210);

`ifdef MEM_SUBWORD_EN
    applyStimulus(1'b1, 1'b0, 32'h8000_0003, 32'h0, F3_B, 1, 32'h80AA_BBCC);
    checkOutput("lb_rdata", {32'd0, mem_rdata}, {32'd0, 32'hFFFF_FF80});
    applyStimulus(1'b0, 1'b1, 32'h8000_0001, 32'h0000_00AB, F3_B, 2, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
